// File: rtl/fifo_write_control.sv
// Write-domain control for the async FIFO: owns the write pointer, syncs the Gray read pointer in.
// Optional almost_full threshold logic is built only when FIFO_ALMOST_FULL_EN is defined.
module fifo_write_control #(
  parameter int ADDR_WIDTH      = 7,
  parameter int AFULL_THRESHOLD = 4
) (
  input  logic                  clock_write,
  input  logic                  write_reset_n,
  input  logic                  write_request,
  input  logic [ADDR_WIDTH:0]   read_pointer,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [ADDR_WIDTH:0]   write_pointer,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   free_count,
  output logic                  overflow
);

  localparam int            PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_WIDTH;

  // Full detection slices the top two Gray bits, and the threshold must fit the free-count range.
  if (ADDR_WIDTH < 2) begin : g_bad_aw
    $error("fifo_write_control: ADDR_WIDTH must be at least 2");
  end
  if (AFULL_THRESHOLD < 0 || AFULL_THRESHOLD > (1 << ADDR_WIDTH)) begin : g_bad_thr
    $error("fifo_write_control: AFULL_THRESHOLD out of range");
  end

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] t_pointer;
  logic [PW-1:0] sync_read_pointer;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_gray;
  logic [PW-1:0] free_next;

  assign write_enable  = write_request & ~full;
  assign write_address = wbin[ADDR_WIDTH-1:0];
  assign wbin_next     = wbin + PW'(write_enable);
  assign wgray_next    = wbin_next ^ (wbin_next >> 1);

  // Writer is one lap ahead when the top two Gray bits differ and the rest match.
  assign full_gray = {~sync_read_pointer[PW-1:PW-2], sync_read_pointer[PW-3:0]};

  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) rbin[i] = ^(sync_read_pointer >> i);
  end

  assign free_next = DEPTH - (wbin_next - rbin);

  // Two-flop synchronizer; nothing may sit between these flops.
  always_ff @(posedge clock_write) begin
    if (!write_reset_n) begin
      t_pointer         <= '0;
      sync_read_pointer <= '0;
    end else begin
      {sync_read_pointer, t_pointer} <= {t_pointer, read_pointer};
    end
  end

  always_ff @(posedge clock_write) begin
    if (!write_reset_n) begin
      wbin          <= '0;
      write_pointer <= '0;
      full          <= 1'b0;
      free_count    <= DEPTH;
      overflow      <= 1'b0;
    end else begin
      wbin          <= wbin_next;
      write_pointer <= wgray_next;
      full          <= (wgray_next == full_gray);
      free_count    <= free_next;
      if (write_request && full) overflow <= 1'b1;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  logic afull_q;

  always_ff @(posedge clock_write) begin
    if (!write_reset_n) afull_q <= 1'b0;
    else                afull_q <= (free_next <= PW'(AFULL_THRESHOLD));
  end

  assign almost_full = afull_q;
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_write_control.sv
// Bench for fifo_write_control: constant vector table, directed corner sequences and a
// random read/write run against an occupancy-count reference model.
module tb_fifo_write_control;

  localparam int AW    = 7;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 128;
  localparam int THR   = 4;
`ifdef FIFO_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [PW-1:0] rptr = '0;
  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [PW-1:0] write_pointer;
  logic          full;
  logic          almost_full;
  logic [PW-1:0] free_count;
  logic          overflow;

  fifo_write_control #(.ADDR_WIDTH(AW), .AFULL_THRESHOLD(THR)) dut (
    .clock_write   (clk),
    .write_reset_n (rst_n),
    .write_request (req),
    .read_pointer  (rptr),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_pointer (write_pointer),
    .full          (full),
    .almost_full   (almost_full),
    .free_count    (free_count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: counts of accepted writes and reads, plus the two-edge visibility lag.
  int          wr_m = 0;
  int          rd_cnt = 0;
  int          rd_seen_q[$];
  bit          full_m, ovf_m, afull_m, model_live;
  int          free_m = DEPTH;
  logic        last_we;
  logic [31:0] last_waddr;

  typedef struct {
    bit rn;
    bit rq;
    bit chk_comb;
    bit we;
    int waddr;
    int wptr;
    bit full;
    int free;
    bit ovf;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int gray(input int v);
    int b;
    b = v & 255;
    return b ^ (b >> 1);
  endfunction

  task automatic do_cycle(input bit rn, input bit rq_i);
    int seen, occ;
    rst_n = rn;
    req   = rq_i;
    rptr  = PW'(gray(rd_cnt));
    #1;
    last_we    = write_enable;
    last_waddr = 32'(write_address);
    if (model_live) begin
      chk("write_enable", 32'(write_enable), 32'(rq_i && !full_m));
      chk("write_address", 32'(write_address), wr_m % DEPTH);
    end
    @(posedge clk);
    if (!rn) begin
      wr_m = 0; ovf_m = 0; full_m = 0; free_m = DEPTH; afull_m = 0;
      rd_seen_q.delete();
      rd_seen_q.push_back(0);
      rd_seen_q.push_back(0);
      model_live = 1;
    end else begin
      if (rq_i && full_m) ovf_m = 1;
      else if (rq_i)      wr_m++;
      seen = rd_seen_q.pop_front();
      rd_seen_q.push_back(rd_cnt);
      occ     = wr_m - seen;
      full_m  = (occ == DEPTH);
      free_m  = DEPTH - occ;
      afull_m = AF_EN && (free_m <= THR);
    end
    #1;
    chk("write_pointer", 32'(write_pointer), gray(wr_m));
    chk("full", 32'(full), 32'(full_m));
    chk("free_count", 32'(free_count), free_m);
    chk("overflow", 32'(overflow), 32'(ovf_m));
    chk("almost_full", 32'(almost_full), 32'(afull_m));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, occ, msb_toggles;
    bit wrapped, prev_msb;
    logic [31:0] prev_waddr;

    // rn rq chk we waddr wptr full free ovf
    tv[0] = '{0, 1, 0, 0, 0, 8'h00, 0, 128, 0};
    tv[1] = '{0, 1, 1, 1, 0, 8'h00, 0, 128, 0};
    tv[2] = '{1, 1, 1, 1, 0, 8'h01, 0, 127, 0};
    tv[3] = '{1, 0, 1, 0, 1, 8'h01, 0, 127, 0};
    tv[4] = '{1, 1, 1, 1, 1, 8'h03, 0, 126, 0};
    tv[5] = '{1, 1, 1, 1, 2, 8'h02, 0, 125, 0};
    tv[6] = '{0, 0, 1, 0, 3, 8'h00, 0, 128, 0};

    rd_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      do_cycle(tv[i].rn, tv[i].rq);
      if (tv[i].chk_comb) begin
        chk("tv_we", 32'(last_we), 32'(tv[i].we));
        chk("tv_waddr", last_waddr, tv[i].waddr);
      end
      chk("tv_wptr", 32'(write_pointer), tv[i].wptr);
      chk("tv_full", 32'(full), 32'(tv[i].full));
      chk("tv_free", 32'(free_count), tv[i].free);
      chk("tv_ovf", 32'(overflow), 32'(tv[i].ovf));
      chk("tv_afull", 32'(almost_full), 32'(0));
    end

    // Fill from empty with the read side idle.
    for (int i = 1; i <= DEPTH; i++) begin
      do_cycle(1, 1);
      chk("fill_waddr", last_waddr, i - 1);
      if (i == 123) chk("fill_afull_123", 32'(almost_full), 32'(0));
      if (i == 124) chk("fill_afull_124", 32'(almost_full), 32'(AF_EN));
      if (i == 127) chk("fill_not_full_127", 32'(full), 32'(0));
    end
    chk("fill_full", 32'(full), 32'(1));
    chk("fill_free", 32'(free_count), 32'(0));
    chk("fill_wptr", 32'(write_pointer), 32'h0C0);

    // Request while full: dropped, sticky overflow.
    do_cycle(1, 1);
    chk("ovf_we", 32'(last_we), 32'(0));
    chk("ovf_wptr", 32'(write_pointer), 32'h0C0);
    chk("ovf_set", 32'(overflow), 32'(1));
    do_cycle(1, 0);
    do_cycle(1, 0);
    chk("ovf_sticky", 32'(overflow), 32'(1));

    // One read becomes visible exactly three edges later.
    rd_cnt = 1;
    do_cycle(1, 0);
    chk("drain_e1_full", 32'(full), 32'(1));
    do_cycle(1, 0);
    chk("drain_e2_full", 32'(full), 32'(1));
    do_cycle(1, 0);
    chk("drain_e3_full", 32'(full), 32'(0));
    chk("drain_e3_free", 32'(free_count), 32'(1));
    do_cycle(1, 1);
    chk("refill_we", 32'(last_we), 32'(1));
    chk("refill_full", 32'(full), 32'(1));
    chk("refill_free", 32'(free_count), 32'(0));

    // Random traffic with occupancy kept below 100 across pointer wrap.
    rd_cnt = 0;
    do_cycle(0, 0);
    cyc = 0; wrapped = 0; msb_toggles = 0;
    prev_msb = write_pointer[PW-1];
    prev_waddr = 0;
    while (wr_m < 300 && cyc < 3000) begin
      occ = wr_m - rd_cnt;
      if (occ > 0 && (occ >= 90 || $urandom_range(0, 1) == 1)) rd_cnt++;
      do_cycle(1, $urandom_range(0, 3) != 0);
      if (last_we === 1'b1) begin
        if (prev_waddr == 127 && last_waddr == 0) wrapped = 1;
        prev_waddr = last_waddr;
      end
      if (write_pointer[PW-1] != prev_msb) msb_toggles++;
      prev_msb = write_pointer[PW-1];
      chk("wrap_no_full", 32'(full), 32'(0));
      cyc++;
    end
    n_cmp++;
    if (cyc >= 3000) begin
      n_bad++;
      $display("FAIL wrap_budget: wrote %0d words, expected 300 within 3000 cycles", wr_m);
    end
    chk("wrap_addr", 32'(wrapped), 32'(1));
    chk("wrap_msb_toggles", 32'(msb_toggles >= 2), 32'(1));

    // Reset in the middle of a burst with overflow set.
    rd_cnt = 0;
    do_cycle(0, 0);
    for (int i = 0; i < 50; i++) do_cycle(1, 1);
    chk("mid_wptr_50", 32'(write_pointer), gray(50));
    for (int i = 50; i < DEPTH; i++) do_cycle(1, 1);
    do_cycle(1, 1);
    chk("mid_ovf_set", 32'(overflow), 32'(1));
    do_cycle(0, 1);
    chk("rst_wptr", 32'(write_pointer), 32'(0));
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_free", 32'(free_count), 32'(128));
    chk("rst_ovf", 32'(overflow), 32'(0));
    chk("rst_afull", 32'(almost_full), 32'(0));
    do_cycle(1, 1);
    chk("post_rst_waddr", last_waddr, 32'(0));
    chk("post_rst_wptr", 32'(write_pointer), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_write_control.md
# fifo_write_control

Write-domain control for the asynchronous FIFO, the counterpart of the write-to-read pointer synchronizer. It owns the write pointer and brings the Gray-coded read pointer into the write clock domain through a 2-flop synchronizer. From the two pointers it generates full, free-count, almost-full and overflow status. It sits between the write-side client, the dual-port FIFO memory write port, and the read-domain control block.

## Interface
Parameters:
- ADDR_WIDTH, 7, memory address width; DEPTH = 2^ADDR_WIDTH (128); pointers are ADDR_WIDTH+1 bits (8).
- AFULL_THRESHOLD, 4, almost_full asserts when free slots <= this value.

Ports:
- clock_write  input  1  write-domain clock; all state updates on its rising edge.
- write_reset_n  input  1  reset, synchronous to clock_write, active-low.
- write_request  input  1  client requests a write this cycle.
- read_pointer  input  ADDR_WIDTH+1  Gray-coded read pointer from the read domain; asynchronous to clock_write.
- write_enable  output  1  memory write strobe, combinational: write_request & ~full.
- write_address  output  ADDR_WIDTH  binary memory write address, the low bits of the binary write pointer.
- write_pointer  output  ADDR_WIDTH+1  registered Gray-coded write pointer, sent to the read domain.
- full  output  1  registered; the FIFO holds DEPTH entries.
- almost_full  output  1  registered threshold flag (see Configuration).
- free_count  output  ADDR_WIDTH+1  registered number of free slots, 0..DEPTH.
- overflow  output  1  sticky flag; set when a write is requested while full.

## Operation
- Internal state: binary pointer wbin (ADDR_WIDTH+1 bits), Gray pointer write_pointer, and synchronizer flops t_pointer and sync_read_pointer.
- Synchronizer:
  - Each edge, {sync_read_pointer, t_pointer} <= {t_pointer, read_pointer}.
  - No logic between the two flops; read_pointer is sampled only by t_pointer.
- Next-state values:
  - wbin_next = wbin + write_enable, modulo 2^(ADDR_WIDTH+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - Each edge: wbin <= wbin_next and write_pointer <= wgray_next.
- Full:
  - full <= (wgray_next == {~sync_read_pointer[MSB:MSB-1], sync_read_pointer[MSB-2:0]}).
- Free count:
  - rbin = Gray-to-binary of sync_read_pointer.
  - free_count <= DEPTH - (wbin_next - rbin), with the subtraction done modulo 2^(ADDR_WIDTH+1).
- Write handling:
  - A write_request while full is dropped: write_enable is 0 and the pointers are unchanged.
  - The same condition sets overflow on the next edge.
  - overflow stays set until reset.
- Reset (write_reset_n low at an edge): wbin, write_pointer, t_pointer, sync_read_pointer, full, almost_full and overflow all go to 0, and free_count goes to DEPTH. This holds even mid-burst.
- The pointer wraps naturally. The MSB distinguishes full from empty, and write_address wraps from DEPTH-1 to 0.

## Timing
- write_enable and write_address are valid in the same cycle as write_request; memory captures on that edge.
- write_pointer, full, free_count and almost_full reflect an accepted write at the edge that accepts it, i.e. 0-cycle registered latency.
- full asserts in the cycle immediately after the write that fills the FIFO, so no extra write can slip in.
- A read_pointer change is seen in sync_read_pointer after 2 edges. full, free_count and almost_full update at the 3rd edge.
- These 3 edges of read-side latency are pessimistic by design: full may stay high late, but never deasserts early.
- Simultaneous write and read-pointer change: both are applied in the same next-state computation. No event is lost.
- Reset takes effect at the first edge with write_reset_n low. Outputs hold reset values until the first edge with write_reset_n high.

## Configuration
- FIFO_ALMOST_FULL_EN defined: almost_full <= (free_next <= AFULL_THRESHOLD), where free_next is the value free_count is about to take.
- FIFO_ALMOST_FULL_EN undefined: almost_full is constant 0, and the threshold comparator and its register are not built. The port remains present.

## Test plan
- Reset: hold write_reset_n low for 2 edges with write_request=1 -> write_pointer=0, full=0, free_count=128, overflow=0, almost_full=0. No write_address advance.
- Fill: read_pointer=0, 128 consecutive writes ->
  - write_address steps 0..127.
  - almost_full rises after the 124th write (free_count=4).
  - After the 128th edge: full=1, free_count=0, write_pointer=8'hC0.
- Overflow: while full, pulse write_request -> write_enable=0, write_pointer stays 8'hC0, overflow=1 from the next edge and stays set after write_request drops.
- Drain visibility: while full, set read_pointer=8'h01 -> full falls exactly 3 edges later with free_count=1. A following write re-asserts full.
- Wrap: a read-domain model advances read_pointer so that occupancy stays below 100, while 300 words are written ->
  - write_address wraps 127->0.
  - write_pointer MSB toggles.
  - full never asserts.
  - free_count always matches the model.
- Reset mid-operation: after 50 writes, plus overflow forced set, drive write_reset_n low for one edge -> all outputs return to reset values, including overflow=0 and free_count=128.
